// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Round-robin arbiter sharing one external logical shifter
//               between two requesters; registered response held until
//               accepted. Optional rotate support via SHIFT_ARBITER_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v0,
  input  logic             v1,
  output logic             rdy0,
  output logic             rdy1,
  input  logic [WIDTH-1:0] num0,
  input  logic [WIDTH-1:0] num1,
  input  logic [AMT_W-1:0] amt0,
  input  logic [AMT_W-1:0] amt1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  output logic [WIDTH-1:0] sh_num,
  output logic [AMT_W-1:0] sh_amt,
  output logic             sh_op,
  input  logic [WIDTH-1:0] sh_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_SHIFT2 = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_sh_num;
  logic [AMT_W-1:0] r_sh_amt;
  logic             r_sh_op;
  logic [WIDTH-1:0] r_acc;

  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_accept;
  logic [WIDTH-1:0] w_num_sel;
  logic [AMT_W-1:0] w_amt_sel;
  logic [1:0]       w_op_sel;

  // Grants are one-hot, so rdy1 alone selects the winning operands
  assign w_accept  = (v0 & w_rdy0) | (v1 & w_rdy1);
  assign w_num_sel = w_rdy1 ? num1 : num0;
  assign w_amt_sel = w_rdy1 ? amt1 : amt0;
  assign w_op_sel  = w_rdy1 ? op1  : op0;

`ifdef SHIFT_ARBITER_ROTATE_EN
  logic r_rot;
`else
  logic w_unused_rot;
  assign w_unused_rot = w_op_sel[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // last_grant=1 means requester 0 wins a tie, and vice versa
        w_rdy0 = v0 & (~v1 | r_last_grant);
        w_rdy1 = v1 & ~w_rdy0;
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
        w_state_nxt = r_rot ? S_SHIFT2 : S_DONE;
`else
        w_state_nxt = S_DONE;
`endif
      end
`ifdef SHIFT_ARBITER_ROTATE_EN
      S_SHIFT2: begin
        w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_sh_num     <= '0;
      r_sh_amt     <= '0;
      r_sh_op      <= 1'b0;
      r_acc        <= '0;
`ifdef SHIFT_ARBITER_ROTATE_EN
      r_rot        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh_num     <= w_num_sel;
            r_sh_amt     <= w_amt_sel;
            r_sh_op      <= w_op_sel[0];
            r_id         <= w_rdy1;
            r_last_grant <= w_rdy1;
`ifdef SHIFT_ARBITER_ROTATE_EN
            r_rot        <= w_op_sel[1] & (w_amt_sel != '0);
`endif
          end
        end
        S_SHIFT: begin
          r_acc <= sh_out;
`ifdef SHIFT_ARBITER_ROTATE_EN
          // Second pass shifts the other way by WIDTH-amt; since WIDTH is
          // 2**AMT_W, that is simply the AMT_W-bit negation of amt
          if (r_rot) begin
            r_sh_amt <= -r_sh_amt;
            r_sh_op  <= ~r_sh_op;
          end
`endif
        end
`ifdef SHIFT_ARBITER_ROTATE_EN
        S_SHIFT2: begin
          r_acc <= r_acc | sh_out;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign rdy0      = w_rdy0;
  assign rdy1      = w_rdy1;
  assign sh_num    = r_sh_num;
  assign sh_amt    = r_sh_amt;
  assign sh_op     = r_sh_op;
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_acc;
  assign rsp_id    = r_id;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter
// Description : Self-checking bench for shift_arbiter: directed cases plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rsp_ready;
  logic [31:0] num0, num1;
  logic [4:0]  amt0, amt1;
  logic [1:0]  op0, op1;
  logic        rdy0, rdy1, sh_op, rsp_valid, rsp_id, busy;
  logic [31:0] sh_num, sh_out, rsp_data;
  logic [4:0]  sh_amt;

  shift_arbiter #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .v0(v0), .v1(v1), .rdy0(rdy0), .rdy1(rdy1),
    .num0(num0), .num1(num1), .amt0(amt0), .amt1(amt1), .op0(op0), .op1(op1),
    .sh_num(sh_num), .sh_amt(sh_amt), .sh_op(sh_op), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  // External combinational shifter the arbiter fronts
  assign sh_out = sh_op ? (sh_num << sh_amt) : (sh_num >> sh_amt);

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state
  bit          m_busy, m_last, m_id, m_just_reset;
  int          m_age, m_lat;
  logic [31:0] m_data;
  bit          acc0, acc1;
  int          obs_grant;
  bit          obs_valid;
  logic [31:0] obs_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_rot(input logic [4:0] a, input logic [1:0] o);
`ifdef SHIFT_ARBITER_ROTATE_EN
    return o[1] && (a != 5'd0);
`else
    return 1'b0 & o[1] & a[0];
`endif
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] n, input logic [4:0] a,
                                             input logic [1:0] o);
    logic [63:0] d;
    d = {n, n};
    if (is_rot(a, o)) begin
      if (o[0]) begin
        d = d << a;
        return d[63:32];
      end
      d = d >> a;
      return d[31:0];
    end
    return o[0] ? (n << a) : (n >> a);
  endfunction

  function automatic int ref_lat(input logic [4:0] a, input logic [1:0] o);
    return is_rot(a, o) ? 3 : 2;
  endfunction

  // One clock: check outputs against the model, take the edge, advance the model
  task automatic cycle_check();
    bit e0, e1, exp_v;
    #1;
    e0 = !m_busy && v0 && (!v1 || m_last);
    e1 = !m_busy && v1 && !e0;
    exp_v = m_busy && (m_age >= m_lat);
    check_eq("rdy0", 32'(rdy0), 32'(e0));
    check_eq("rdy1", 32'(rdy1), 32'(e1));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check_eq("rsp_data", rsp_data, m_data);
      check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    if (m_just_reset) begin
      check_eq("rst_sh_num", sh_num, 32'h0);
      check_eq("rst_sh_amt", 32'(sh_amt), 32'h0);
      check_eq("rst_sh_op", 32'(sh_op), 32'h0);
      check_eq("rst_rsp_data", rsp_data, 32'h0);
      check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
    end
    obs_grant = rdy0 ? 0 : (rdy1 ? 1 : -1);
    obs_valid = rsp_valid;
    obs_data  = rsp_data;
    @(posedge clk);
    m_just_reset = rst;
    acc0 = !rst && e0;
    acc1 = !rst && e1;
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (!m_busy) begin
      if (e0 || e1) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = e1;
        m_last = e1;
        m_data = e1 ? ref_result(num1, amt1, op1) : ref_result(num0, amt0, op0);
        m_lat  = e1 ? ref_lat(amt1, op1) : ref_lat(amt0, op0);
      end
    end else if (exp_v && rsp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
    #1;
  endtask

  task automatic do_op(input string tag, input int who, input logic [31:0] n,
                       input logic [4:0] a, input logic [1:0] o,
                       input logic [31:0] exp, input int exp_lat);
    int  lat_obs;
    bit  got;
    logic [31:0] data_obs;
    rsp_ready = 1'b1;
    v0 = (who == 0);
    v1 = (who == 1);
    if (who == 0) begin num0 = n; amt0 = a; op0 = o; end
    else          begin num1 = n; amt1 = a; op1 = o; end
    cycle_check();
    v0 = 1'b0;
    v1 = 1'b0;
    got = 1'b0;
    lat_obs = 0;
    data_obs = '0;
    for (int i = 1; i <= 8 && m_busy; i++) begin
      cycle_check();
      if (obs_valid && !got) begin
        got      = 1'b1;
        lat_obs  = i;
        data_obs = obs_data;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat_obs), 32'(exp_lat));
    check_eq({tag, "_data"}, data_obs, exp);
  endtask

  initial begin
    int k;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
    num0 = '0; num1 = '0; amt0 = '0; amt1 = '0; op0 = '0; op1 = '0;
    m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_age = 0; m_lat = 2; m_data = '0;
    acc0 = 1'b0; acc1 = 1'b0;
    repeat (2) @(posedge clk);
    m_just_reset = 1'b1;
    #1;
    rst = 1'b0;

    do_op("left4", 0, 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_0F00, 2);
    do_op("right31", 1, 32'h8000_0000, 5'd31, 2'b00, 32'h0000_0001, 2);
    do_op("amt0", 0, 32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF, 2);
`ifdef SHIFT_ARBITER_ROTATE_EN
    do_op("rotl1", 0, 32'h8000_0001, 5'd1, 2'b11, 32'h0000_0003, 3);
    do_op("rotr1", 1, 32'h8000_0001, 5'd1, 2'b10, 32'hC000_0000, 3);
`endif

    // Alternation under constant contention, starting fresh from reset
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b1;
    num0 = 32'h1234_5678; amt0 = 5'd3; op0 = 2'b01;
    num1 = 32'hF0F0_0F0F; amt1 = 5'd7; op1 = 2'b00;
    k = 0;
    for (int i = 0; i < 13; i++) begin
      cycle_check();
      if (obs_grant >= 0) begin
        check_eq("alt_grant", 32'(obs_grant), 32'(k % 2));
        k++;
      end
    end
    check_eq("alt_count", 32'(k >= 4), 32'h1);
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 4 && m_busy; i++) cycle_check();

    // Consumer stall: response must hold with no grants while v1 waits
    v0 = 1'b1; num0 = 32'hA5A5_0001; amt0 = 5'd9; op0 = 2'b01;
    rsp_ready = 1'b0;
    cycle_check();
    v0 = 1'b0; v1 = 1'b1; num1 = 32'h0000_FFFF; amt1 = 5'd2; op1 = 2'b00;
    for (int i = 0; i < 8; i++) cycle_check();
    rsp_ready = 1'b1;
    cycle_check();
    cycle_check();
    v1 = 1'b0;
    for (int i = 0; i < 4 && m_busy; i++) cycle_check();

    // Reset while the shifter pass is in flight
    v0 = 1'b1; num0 = 32'h0F00_00F0; amt0 = 5'd1; op0 = 2'b01;
    cycle_check();
    v0 = 1'b0; rst = 1'b1;
    cycle_check();
    rst = 1'b0; v1 = 1'b1; num1 = 32'h0000_0100; amt1 = 5'd8; op1 = 2'b00;
    cycle_check();
    v1 = 1'b0;
    for (int i = 0; i < 4 && m_busy; i++) cycle_check();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!v0 || acc0) begin
        v0 = 1'($urandom);
        num0 = $urandom;
        amt0 = ($urandom_range(3, 0) == 0) ? (1'($urandom) ? 5'd31 : 5'd0) : 5'($urandom);
        op0 = 2'($urandom);
      end
      if (!v1 || acc1) begin
        v1 = 1'($urandom);
        num1 = $urandom;
        amt1 = ($urandom_range(3, 0) == 0) ? (1'($urandom) ? 5'd31 : 5'd0) : 5'($urandom);
        op1 = 2'($urandom);
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      rst = ($urandom_range(149, 0) == 0);
      cycle_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
